// File: rtl/tff_seq_ctrl_pkg.sv
// Shared encodings for the T flip-flop sequencing controller.
package tff_seq_ctrl_pkg;
   typedef enum logic [1:0] {
      CMD_UP    = 2'b00,
      CMD_DOWN  = 2'b01,
      CMD_LOAD  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_LOAD = 2'b10,
      S_DONE = 2'b11
   } state_t;
endpackage

// File: rtl/tff_seq_ctrl_if.sv
// Command/observe bundle between a requester and the sequencing controller.
interface tff_seq_ctrl_if #(parameter int WIDTH = 4, parameter int STEPW = 8);
   logic             start;
   logic [1:0]       cmd;
   logic [STEPW-1:0] steps;
   logic [WIDTH-1:0] load_val;
   logic             hold;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] t_out;
   logic             busy;
   logic             done;
   logic             wrap;

   modport master (output start, cmd, steps, load_val, hold,
                   input  q, qn, t_out, busy, done, wrap);
   modport slave  (input  start, cmd, steps, load_val, hold,
                   output q, qn, t_out, busy, done, wrap);
endinterface

// File: rtl/tff_seq_ctrl_bank.sv
// Bank of WIDTH independent T flip-flops; bit i toggles on an edge when t[i] is set.
module tff_bank #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
);
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      always_ff @(posedge clk or posedge rst) begin
         if (rst)       q[g] <= 1'b0;
         else if (t[g]) q[g] <= ~q[g];
      end
   end

   assign qn = ~q;
endmodule

// File: rtl/tff_seq_ctrl.sv
// Command sequencer driving the T inputs of a toggle-cell bank (count up/down, load, clear).
module tff_seq_ctrl
   import tff_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int STEPW = 8
) (
   input  logic         clk,
   input  logic         rst,
   tff_seq_ctrl_if.slave bus
);
   state_t           state;
   cmd_t             cmd_r;
   logic [STEPW-1:0] rem;
   logic [WIDTH-1:0] ld_r;
   logic [WIDTH-1:0] q, qn, t;
   logic [WIDTH-1:0] up_m, dn_m;
   logic             busy_r, done_r, wrap_r;
   logic             step_en;

   // Bit i toggles when every lower bit is at its carry (UP) / borrow (DOWN) value.
   always_comb begin
      logic [WIDTH-1:0] lm;
      lm   = '0;
      up_m = '0;
      dn_m = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lm      = WIDTH'((1 << i) - 1);
         up_m[i] = ((q & lm) == lm);
         dn_m[i] = ((q & lm) == '0);
      end
   end

   assign step_en = (state == S_RUN) && !bus.hold;

   always_comb begin
      t = '0;
      case (state)
         S_RUN:   if (!bus.hold) t = (cmd_r == CMD_UP) ? up_m : dn_m;
         S_LOAD:  t = (cmd_r == CMD_LOAD) ? (q ^ ld_r) : q;
         default: t = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cmd_r  <= CMD_UP;
         rem    <= '0;
         ld_r   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= step_en && (((cmd_r == CMD_UP) && (&q)) ||
                               ((cmd_r == CMD_DOWN) && !(|q)));
         done_r <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) begin
               cmd_r <= cmd_t'(bus.cmd);
               rem   <= bus.steps;
               ld_r  <= bus.load_val;
               if (bus.cmd[1]) begin
                  state  <= S_LOAD;
                  busy_r <= 1'b1;
               end else if (bus.steps == '0) begin
                  state  <= S_DONE;
                  done_r <= 1'b1;
               end else begin
                  state  <= S_RUN;
                  busy_r <= 1'b1;
               end
            end
            S_RUN: if (!bus.hold) begin
               rem <= rem - 1'b1;
               if (rem == STEPW'(1)) begin
                  state  <= S_DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            S_LOAD: begin
               state  <= S_DONE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   tff_bank #(.WIDTH(WIDTH)) u_bank (
      .clk (clk),
      .rst (rst),
      .t   (t),
      .q   (q),
      .qn  (qn)
   );

   assign bus.q     = q;
   assign bus.qn    = qn;
   assign bus.t_out = t;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.wrap  = wrap_r;
endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Randomized bench for tff_seq_ctrl against a per-command arithmetic reference model.
module tb_tff_seq_ctrl;
   localparam int WIDTH = 4;
   localparam int STEPW = 8;
   localparam int MSK   = (1 << WIDTH) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   tff_seq_ctrl_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

   tff_seq_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int mq    = 0;
   bit mwrap = 1'b0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(string tag, int eb, int ed, int et);
      chk({tag, ".q"},     32'(bus.q),     32'(mq));
      chk({tag, ".qn"},    32'(bus.qn),    32'((~mq) & MSK));
      chk({tag, ".busy"},  32'(bus.busy),  32'(eb));
      chk({tag, ".done"},  32'(bus.done),  32'(ed));
      chk({tag, ".wrap"},  32'(bus.wrap),  32'(mwrap));
      chk({tag, ".t_out"}, 32'(bus.t_out), 32'(et));
   endtask

   // While a command is in flight the start/cmd lines may carry junk that must be ignored.
   task automatic noise(bit poke);
      if (poke) begin
         bus.start    = 1'($urandom);
         bus.cmd      = 2'($urandom);
         bus.steps    = STEPW'($urandom);
         bus.load_val = WIDTH'($urandom);
      end else begin
         bus.start = 1'b0;
      end
   endtask

   task automatic run_cmd(int c, int n, int lv, logic [31:0] hpat, bit poke);
      int tgt, rem, nq, j;
      @(negedge clk);
      bus.start = 1'b1; bus.cmd = 2'(c); bus.steps = STEPW'(n);
      bus.load_val = WIDTH'(lv); bus.hold = 1'($urandom);
      @(posedge clk);
      mwrap = 1'b0;
      if (c >= 2) begin
         tgt = (c == 2) ? (lv & MSK) : 0;
         @(negedge clk); noise(poke); #1;
         check_outs("load", 1, 0, mq ^ tgt);
         @(posedge clk);
         mq = tgt; mwrap = 1'b0;
      end else if (n > 0) begin
         rem = n; j = 0;
         while (rem > 0) begin
            @(negedge clk); noise(poke);
            bus.hold = (j < 32) ? hpat[j] : 1'b0;
            j++;
            #1;
            nq = (c == 0) ? ((mq + 1) & MSK) : ((mq - 1) & MSK);
            check_outs("run", 1, 0, bus.hold ? 0 : (mq ^ nq));
            @(posedge clk);
            if (!bus.hold) begin
               mwrap = (c == 0) ? (mq == MSK) : (mq == 0);
               mq = nq; rem--;
            end else begin
               mwrap = 1'b0;
            end
         end
      end
      @(negedge clk); noise(poke); bus.hold = 1'($urandom); #1;
      check_outs("done", 0, 1, 0);
      @(posedge clk);
      mwrap = 1'b0;
      @(negedge clk); bus.start = 1'b0; bus.hold = 1'($urandom); #1;
      check_outs("idle", 0, 0, 0);
   endtask

   initial begin
      bus.start = 1'b0; bus.cmd = 2'd0; bus.steps = '0; bus.load_val = '0; bus.hold = 1'b0;
      #1;
      check_outs("reset", 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check_outs("rel", 0, 0, 0);

      run_cmd(0, 5, 0, 32'd0, 1'b0);          // 0 -> 5
      run_cmd(2, 0, 10, 32'd0, 1'b0);         // load A
      run_cmd(1, 3, 0, 32'd0, 1'b0);          // 9,8,7
      run_cmd(2, 0, 14, 32'd0, 1'b0);         // load E
      run_cmd(0, 3, 0, 32'd0, 1'b0);          // F,0,1 with wrap
      run_cmd(3, 0, 0, 32'd0, 1'b0);          // clear
      run_cmd(1, 1, 0, 32'd0, 1'b0);          // F with wrap
      run_cmd(3, 0, 0, 32'd0, 1'b0);
      run_cmd(0, 4, 0, 32'b1100, 1'b0);       // hold two cycles at q=2

      // Abort: second start mid-run ignored, then reset between edges.
      @(negedge clk);
      bus.start = 1'b1; bus.cmd = 2'd0; bus.steps = STEPW'(8); bus.hold = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.start = (i == 1); bus.cmd = 2'd3;
         #1 check_outs("abort", 1, 0, mq ^ ((mq + 1) & MSK));
         @(posedge clk);
         mq = (mq + 1) & MSK; mwrap = 1'b0;
      end
      @(negedge clk); bus.start = 1'b0;
      #5 rst = 1'b1;
      #1 mq = 0; mwrap = 1'b0;
      check_outs("rst_mid", 0, 0, 0);
      @(negedge clk); rst = 1'b0;
      #1 check_outs("post_rst", 0, 0, 0);
      repeat (2) begin
         @(negedge clk); #1 check_outs("no_done", 0, 0, 0);
      end

      run_cmd(0, 0, 0, 32'd0, 1'b0);          // zero steps: done only

      for (int k = 0; k < 60; k++) begin
         int c;
         c = int'($urandom_range(0, 3));
         run_cmd(c, int'($urandom_range(0, 20)), int'($urandom_range(0, MSK)),
                 $urandom & $urandom, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
